// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-rate divider, delayed sync/de
// and a frame-aligned start/stop handshake.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV = 4,
    parameter int CHAR_W = 8,
    parameter int CHAR_H = 16,
    parameter int PIPE_DLY = 2,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW = $clog2(H_TOTAL),
    localparam int YW = $clog2(V_TOTAL),
    localparam int CW = $clog2(H_ACTIVE / CHAR_W),
    localparam int RW = $clog2(V_ACTIVE / CHAR_H),
    localparam int GXW = $clog2(CHAR_W),
    localparam int GYW = $clog2(CHAR_H)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           enable_i,
    output logic           busy_o,
    output logic           pix_en_o,
    output logic [XW-1:0]  x_o,
    output logic [YW-1:0]  y_o,
    output logic [CW-1:0]  col_o,
    output logic [RW-1:0]  row_o,
    output logic [GXW-1:0] glyph_x_o,
    output logic [GYW-1:0] glyph_y_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o,
    output logic           frame_start_o,
    output logic           line_start_o
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DV1 = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] HA = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS0 = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS1 = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] HT1 = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] VA = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS0 = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS1 = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] VT1 = YW'(V_TOTAL - 1);
    localparam logic [2:0] IDLE_LVL = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t state, state_n;
    logic [DW-1:0] div, div_n;
    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;
    logic run_n, pix_n, wrap_x, last_pix, line_n, frame_n;
    logic [2:0] raw_n;
    // {de, hsync, vsync} levels; stage 0 tracks the current coordinates every clk
    logic [2:0] pipe [0:PIPE_DLY];

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_n;

    always_comb begin
        wrap_x = pix_en_o && x_o == HT1;
        last_pix = wrap_x && y_o == VT1;
        state_n = state == IDLE ? (enable_i ? RUN : IDLE)
                : enable_i ? RUN
                : (state == STOPPING && last_pix) ? IDLE : STOPPING;
    end

    always_comb begin
        run_n = state_n != IDLE;
        div_n = (state == IDLE || !run_n || div == DV1) ? '0 : div + 1'b1;
        pix_n = run_n && div_n == DV1;
        x_n = (state == IDLE || wrap_x) ? '0 : pix_en_o ? x_o + 1'b1 : x_o;
        y_n = state == IDLE ? '0 : wrap_x ? (y_o == VT1 ? '0 : y_o + 1'b1) : y_o;
        line_n = run_n && (state == IDLE || wrap_x);
        frame_n = run_n && (state == IDLE || last_pix);
        raw_n = run_n ? {x_n < HA && y_n < VA,
                         (x_n >= HS0 && x_n < HS1) ? HSYNC_POL : ~HSYNC_POL,
                         (y_n >= VS0 && y_n < VS1) ? VSYNC_POL : ~VSYNC_POL} : IDLE_LVL;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div <= '0;
            busy_o <= 1'b0;
            pix_en_o <= 1'b0;
            x_o <= '0;
            y_o <= '0;
            col_o <= '0;
            row_o <= '0;
            glyph_x_o <= '0;
            glyph_y_o <= '0;
            line_start_o <= 1'b0;
            frame_start_o <= 1'b0;
            for (int i = 0; i <= PIPE_DLY; i++) pipe[i] <= IDLE_LVL;
        end else begin
            div <= div_n;
            busy_o <= run_n;
            pix_en_o <= pix_n;
            x_o <= x_n;
            y_o <= y_n;
            col_o <= CW'(x_n >> GXW);
            row_o <= RW'(y_n >> GYW);
            glyph_x_o <= x_n[GXW-1:0];
            glyph_y_o <= y_n[GYW-1:0];
            line_start_o <= line_n;
            frame_start_o <= frame_n;
            pipe[0] <= raw_n;
            // delay stages advance per pixel tick and flush when scan-out halts
            for (int i = 1; i <= PIPE_DLY; i++)
                pipe[i] <= !run_n ? IDLE_LVL : pix_en_o ? pipe[i-1] : pipe[i];
        end
    end

    assign {de_o, hsync_o, vsync_o} = pipe[PIPE_DLY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of two small-raster instances (14x7 total, 8x4 active)
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    int checks = 0;
    int errors = 0;

    logic busy_a, pix_a, hs_a, vs_a, de_a, fs_a, ls_a, row_a, gx_a, gy_a;
    logic busy_b, pix_b, hs_b, vs_b, de_b, fs_b, ls_b, row_b, gx_b, gy_b;
    logic [3:0] x_a, x_b;
    logic [2:0] y_a, y_b;
    logic [1:0] col_a, col_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .CHAR_W(2), .CHAR_H(2), .PIPE_DLY(0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en_a), .busy_o(busy_a), .pix_en_o(pix_a),
        .x_o(x_a), .y_o(y_a), .col_o(col_a), .row_o(row_a), .glyph_x_o(gx_a), .glyph_y_o(gy_a),
        .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a), .frame_start_o(fs_a), .line_start_o(ls_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(4), .CHAR_W(2), .CHAR_H(2), .PIPE_DLY(3)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en_b), .busy_o(busy_b), .pix_en_o(pix_b),
        .x_o(x_b), .y_o(y_b), .col_o(col_b), .row_o(row_b), .glyph_x_o(gx_b), .glyph_y_o(gy_b),
        .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b), .frame_start_o(fs_b), .line_start_o(ls_b)
    );

    function automatic logic [18:0] pk(input logic [3:0] x, input logic [2:0] y, input logic [1:0] col,
                                       input logic row, gx, gy, de, hs, vs, ls, fs, pix, busy);
        return {x, y, col, row, gx, gy, de, hs, vs, ls, fs, pix, busy};
    endfunction

    // p: pixel index of current coords, q: pixel index seen at sync/de (negative = pipeline empty)
    function automatic logic [18:0] model(input int p, input int q, input bit fresh, input bit pix);
        int x, y, qx, qy;
        logic de, hs, vs, ls;
        x = p % 14;
        y = (p / 14) % 7;
        if (q < 0) begin
            de = 1'b0;
            hs = 1'b1;
            vs = 1'b1;
        end else begin
            qx = q % 14;
            qy = (q / 14) % 7;
            de = qx < 8 && qy < 4;
            hs = !(qx >= 10 && qx <= 11);
            vs = qy != 5;
        end
        ls = fresh && x == 0;
        return pk(4'(x), 3'(y), 2'((x >> 1) & 3), 1'((y >> 1) & 1), 1'(x & 1), 1'(y & 1),
                  de, hs, vs, ls, ls && y == 0, pix, 1'b1);
    endfunction

    function automatic logic [18:0] obs_a();
        return pk(x_a, y_a, col_a, row_a, gx_a, gy_a, de_a, hs_a, vs_a, ls_a, fs_a, pix_a, busy_a);
    endfunction

    function automatic logic [18:0] obs_b();
        return pk(x_b, y_b, col_b, row_b, gx_b, gy_b, de_b, hs_b, vs_b, ls_b, fs_b, pix_b, busy_b);
    endfunction

    task automatic chk(input string tag, input int n, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s@%0d: got %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [18:0] rst_vec;

    initial begin
        rst_vec = pk(4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_b", 0, obs_b(), rst_vec);
        chk("reset_a", 0, obs_a(), rst_vec);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_b", i, obs_b(), rst_vec);
            chk("idle_a", i, obs_a(), rst_vec);
        end

        // CLK_DIV=1, PIPE_DLY=0: three frames, stop/resume mid-frame, then stop to frame end
        en_a = 1'b1;
        for (int t = 0; t < 500; t++) begin
            tick();
            chk("run_a", t, obs_a(), t < 490 ? model(t, t, 1'b1, 1'b1) : rst_vec);
            en_a = !((t >= 321 && t < 349) || t >= 405);
        end

        // CLK_DIV=4, PIPE_DLY=3: full frame plus part of the next
        en_b = 1'b1;
        for (int c = 0; c < 462; c++) begin
            tick();
            chk("run_b", c, obs_b(), model(c / 4, c / 4 - 3, c % 4 == 0, c % 4 == 3));
        end

        // asynchronous reset mid-line with de high in the delay line
        rst = 1'b1;
        #1;
        chk("async_rst_b", 0, obs_b(), rst_vec);
        tick();
        chk("held_rst_b", 1, obs_b(), rst_vec);
        rst = 1'b0;
        for (int c = 0; c < 21; c++) begin
            tick();
            chk("restart_b", c, obs_b(), model(c / 4, c / 4 - 3, c % 4 == 0, c % 4 == 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
